// File: rtl/delta_dec.sv
// Delta-stream decoder: rebuilds an LEN-bit sample from a 1-bit up/down stream, saturating at
// both rails. Define DELTA_DEC_ADAPT_EN to compile in run-length step adaptation.
module delta_dec #(
    parameter int unsigned LEN      = 8,
    parameter int unsigned INIT     = 2 ** (LEN - 1),
    parameter int unsigned STEP     = 1,
    parameter int unsigned MAX_STEP = 16,
    parameter int unsigned RUN      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    input  logic           in_bit,
    output logic           out_valid,
    output logic [LEN-1:0] out_sample,
    output logic           out_sat
);

    // Two guard bits so acc + step can never wrap before the clamp decision.
    localparam int unsigned EW = LEN + 2;
    localparam logic [EW-1:0] AccMax = {2'b00, {LEN{1'b1}}};

    if (!((MAX_STEP < (2 ** LEN)) && (STEP >= 1) && (STEP <= MAX_STEP) && (RUN >= 1)))
    begin : g_bad_params
        $error("delta_dec: invalid parameter set");
    end

    logic [LEN-1:0] acc_q, acc_d;
    logic           valid_q, valid_d;
    logic           sat_q, sat_d;
    logic [EW-1:0]  acc_ext, step_ext, up_sum;
    logic           up_clip, dn_clip;

`ifdef DELTA_DEC_ADAPT_EN
    localparam int unsigned SW = $clog2(MAX_STEP) + 1;
    localparam int unsigned RW = $clog2(RUN + 1);

    logic [SW-1:0] step_q, step_d;
    logic [RW-1:0] run_q, run_d;
    logic          prev_q, prev_d;
    logic          have_q, have_d;
    logic [SW:0]   step_dbl;
    logic [SW-1:0] step_half;

    assign step_ext  = EW'(step_q);
    assign step_dbl  = {step_q, 1'b0};
    assign step_half = step_q >> 1;
`else
    assign step_ext = EW'(STEP);
`endif

    assign acc_ext = EW'(acc_q);
    assign up_sum  = acc_ext + step_ext;
    assign up_clip = up_sum > AccMax;
    assign dn_clip = step_ext > acc_ext;

    always_comb begin
        acc_d   = acc_q;
        valid_d = 1'b0;
        sat_d   = sat_q;
`ifdef DELTA_DEC_ADAPT_EN
        step_d  = step_q;
        run_d   = run_q;
        prev_d  = prev_q;
        have_d  = have_q;
`endif
        if (clr) begin
            acc_d  = LEN'(INIT);
            sat_d  = 1'b0;
`ifdef DELTA_DEC_ADAPT_EN
            step_d = SW'(STEP);
            run_d  = '0;
            prev_d = 1'b0;
            have_d = 1'b0;
`endif
        end else if (in_valid) begin
            valid_d = 1'b1;
            if (in_bit) begin
                acc_d = up_clip ? {LEN{1'b1}} : up_sum[LEN-1:0];
                sat_d = up_clip;
            end else begin
                acc_d = dn_clip ? '0 : acc_q - step_ext[LEN-1:0];
                sat_d = dn_clip;
            end
`ifdef DELTA_DEC_ADAPT_EN
            // Adaptation only affects the step used by the next accepted bit.
            prev_d = in_bit;
            if (!have_q) begin
                run_d  = '0;
                have_d = 1'b1;
            end else if (in_bit == prev_q) begin
                if (RW'(run_q + 1'b1) == RW'(RUN)) begin
                    step_d = (step_dbl > (SW + 1)'(MAX_STEP)) ? SW'(MAX_STEP) : step_dbl[SW-1:0];
                    run_d  = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                step_d = (step_half < SW'(STEP)) ? SW'(STEP) : step_half;
                run_d  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= LEN'(INIT);
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
`ifdef DELTA_DEC_ADAPT_EN
            step_q  <= SW'(STEP);
            run_q   <= '0;
            prev_q  <= 1'b0;
            have_q  <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
`ifdef DELTA_DEC_ADAPT_EN
            step_q  <= step_d;
            run_q   <= run_d;
            prev_q  <= prev_d;
            have_q  <= have_d;
`endif
        end
    end

    assign out_sample = acc_q;
    assign out_valid  = valid_q;
    assign out_sat    = sat_q;

endmodule

// File: tb/tb_delta_dec.sv
// Randomized bench for delta_dec against a plain-arithmetic reference model, plus directed
// sequences with literal expected samples. Honours DELTA_DEC_ADAPT_EN like the design.
module tb_delta_dec;

    localparam int LEN      = 8;
    localparam int INIT     = 128;
    localparam int STEP     = 1;
    localparam int MAX_STEP = 16;
    localparam int RUN      = 3;
    localparam int TOP      = 255;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_bit = 1'b0;
    logic           out_valid;
    logic [LEN-1:0] out_sample;
    logic           out_sat;

    delta_dec #(
        .LEN      (LEN),
        .INIT     (INIT),
        .STEP     (STEP),
        .MAX_STEP (MAX_STEP),
        .RUN      (RUN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_acc, m_step, m_run;
    bit m_prev, m_have, m_valid, m_sat;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc   = INIT;
        m_step  = STEP;
        m_run   = 0;
        m_prev  = 1'b0;
        m_have  = 1'b0;
        m_valid = 1'b0;
        m_sat   = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit v, input bit b);
        int nxt;
        if (!r || c) begin
            model_clear();
        end else if (v) begin
            nxt   = b ? m_acc + m_step : m_acc - m_step;
            m_sat = 1'b0;
            if (nxt > TOP) begin
                nxt   = TOP;
                m_sat = 1'b1;
            end else if (nxt < 0) begin
                nxt   = 0;
                m_sat = 1'b1;
            end
            m_acc   = nxt;
            m_valid = 1'b1;
`ifdef DELTA_DEC_ADAPT_EN
            if (!m_have) begin
                m_run  = 0;
                m_have = 1'b1;
            end else if (b == m_prev) begin
                if (m_run + 1 == RUN) begin
                    m_step = (2 * m_step > MAX_STEP) ? MAX_STEP : 2 * m_step;
                    m_run  = 0;
                end else begin
                    m_run = m_run + 1;
                end
            end else begin
                m_step = (m_step / 2 < STEP) ? STEP : m_step / 2;
                m_run  = 0;
            end
            m_prev = b;
`endif
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive, let the edge happen, update the model, compare away from the edge.
    task automatic cyc(input bit r, input bit c, input bit v, input bit b);
        rst_n    = r;
        clr      = c;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        model_step(r, c, v, b);
        #1;
        check_eq("sample", 32'(out_sample), 32'(m_acc));
        check_eq("valid", 32'(out_valid), 32'(m_valid));
        check_eq("sat", 32'(out_sat), 32'(m_sat));
    endtask

    task automatic bit_exp(input bit b, input int exp);
        cyc(1'b1, 1'b0, 1'b1, b);
        check_eq("tbl_sample", 32'(out_sample), 32'(exp));
    endtask

    initial begin
        int bias;
        bit last;
        model_clear();

        // Reset held with traffic present
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rst_sample", 32'(out_sample), 32'h80);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sat", 32'(out_sat), 32'd0);

`ifndef DELTA_DEC_ADAPT_EN
        begin
            int exp_fix [7] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h84, 8'h83};
            bit bits_fix [7] = '{1, 1, 1, 1, 1, 0, 0};
            for (int i = 0; i < 7; i++) begin
                bit_exp(bits_fix[i], exp_fix[i]);
                check_eq("fix_valid", 32'(out_valid), 32'd1);
                check_eq("fix_sat", 32'(out_sat), 32'd0);
            end
        end
        // Saturation at the top rail
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 130; k++) begin
            bit_exp(1'b1, (128 + k > 255) ? 255 : 128 + k);
            check_eq("top_sat", 32'(out_sat), (k >= 128) ? 32'd1 : 32'd0);
        end
        bit_exp(1'b0, 8'hFE);
        check_eq("top_unsat", 32'(out_sat), 32'd0);
`else
        begin
            int exp_ad [8] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h88, 8'h86, 8'h85};
            bit bits_ad [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
            for (int i = 0; i < 8; i++) bit_exp(bits_ad[i], exp_ad[i]);
        end
`endif

        // Gaps and clr
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        bit_exp(1'b1, 8'h81);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("gap_hold", 32'(out_sample), 32'h81);
            check_eq("gap_valid", 32'(out_valid), 32'd0);
        end
        bit_exp(1'b1, 8'h82);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("clr_sample", 32'(out_sample), 32'h80);
        check_eq("clr_valid", 32'(out_valid), 32'd0);
        bit_exp(1'b1, 8'h81);

        // Mid-stream reset after the step has grown
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        bit_exp(1'b1, 8'h81);
        bit_exp(1'b1, 8'h82);
        bit_exp(1'b1, 8'h83);
        bit_exp(1'b1, 8'h84);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("mrst_sample", 32'(out_sample), 32'h80);
        bit_exp(1'b1, 8'h81);

        // Randomized traffic with drifting bias so both rails get exercised
        bias = 50;
        last = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            bit r, c, v, b;
            if (n % 256 == 0) bias = $urandom_range(0, 2) * 45 + 5;
            r = ($urandom_range(0, 199) != 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 60) b = last;
            else b = ($urandom_range(0, 99) < bias);
            last = b;
            cyc(r, c, v, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
